// File: rtl/multi_chunk_clause_evaluator.sv
// Streams one clause as LITS_PER_CHUNK-wide beats and reports SAT / UNIT / CONFLICT / UNRESOLVED.
// Accumulates satisfied and free literals across beats; the result is held until the consumer takes it.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module multi_chunk_clause_evaluator #(
    parameter int unsigned LITS_PER_CHUNK = 5,
    parameter int unsigned VAR_BITS       = `MAX_VARS_BITS,
    parameter int unsigned MAX_CHUNKS     = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_first,
    input  logic                               in_last,
    input  logic [LITS_PER_CHUNK-1:0]          in_mask,
    input  logic [LITS_PER_CHUNK-1:0]          in_unassign,
    input  logic [LITS_PER_CHUNK-1:0]          in_val,
    input  logic [LITS_PER_CHUNK-1:0]          in_pole,
    input  logic [LITS_PER_CHUNK*VAR_BITS-1:0] in_variable,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [1:0]                         out_status,
    output logic [VAR_BITS-1:0]                out_implied_var,
    output logic                               out_new_val,
    output logic                               out_overflow
);

    localparam int unsigned CNT_W = $clog2(MAX_CHUNKS + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;
    typedef enum logic [1:0] {
        ST_UNRESOLVED = 2'd0,
        ST_SAT        = 2'd1,
        ST_UNIT       = 2'd2,
        ST_CONFLICT   = 2'd3
    } status_t;

    state_t              state;
    logic                acc_sat;
    logic [1:0]          acc_free;
    logic [VAR_BITS-1:0] acc_var;
    logic                acc_pole;
    logic [CNT_W-1:0]    acc_cnt;

    logic                restart;
    logic                nxt_sat;
    logic [1:0]          nxt_free;
    logic [VAR_BITS-1:0] nxt_var;
    logic                nxt_pole;
    logic [CNT_W-1:0]    nxt_cnt;
    status_t             nxt_status;

    assign in_ready = (state != RESULT);

    // Merge the current beat into either the running accumulators or a fresh clause.
    always_comb begin
        restart  = (state != ACCUM) || in_first;
        nxt_sat  = restart ? 1'b0 : acc_sat;
        nxt_free = restart ? 2'd0 : acc_free;
        nxt_var  = restart ? '0 : acc_var;
        nxt_pole = restart ? 1'b0 : acc_pole;
        nxt_cnt  = restart ? '0 : acc_cnt;
        if (nxt_cnt != CNT_SAT) begin
            nxt_cnt = nxt_cnt + 1'b1;
        end
        for (int unsigned i = 0; i < LITS_PER_CHUNK; i++) begin
            if (in_mask[i]) begin
                if (in_unassign[i]) begin
                    if (nxt_free == 2'd0) begin
                        nxt_var  = in_variable[i*VAR_BITS +: VAR_BITS];
                        nxt_pole = in_pole[i];
                    end
                    if (nxt_free != 2'd2) begin
                        nxt_free = nxt_free + 2'd1;
                    end
                end else if (in_val[i] ^ in_pole[i]) begin
                    nxt_sat = 1'b1;
                end
            end
        end
        if (nxt_sat) begin
            nxt_status = ST_SAT;
        end else if (nxt_free == 2'd1) begin
            nxt_status = ST_UNIT;
        end else if (nxt_free == 2'd0) begin
            nxt_status = ST_CONFLICT;
        end else begin
            nxt_status = ST_UNRESOLVED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            acc_sat         <= 1'b0;
            acc_free        <= 2'd0;
            acc_var         <= '0;
            acc_pole        <= 1'b0;
            acc_cnt         <= '0;
            out_valid       <= 1'b0;
            out_status      <= 2'd0;
            out_implied_var <= '0;
            out_new_val     <= 1'b0;
            out_overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_sat  <= nxt_sat;
                        acc_free <= nxt_free;
                        acc_var  <= nxt_var;
                        acc_pole <= nxt_pole;
                        acc_cnt  <= nxt_cnt;
                        if (in_last) begin
                            state           <= RESULT;
                            out_valid       <= 1'b1;
                            out_status      <= nxt_status;
                            out_implied_var <= (nxt_status == ST_UNIT) ? nxt_var : '0;
                            out_new_val     <= (nxt_status == ST_UNIT) ? ~nxt_pole : 1'b0;
                            out_overflow    <= (nxt_cnt > CNT_MAX);
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state           <= IDLE;
                        out_valid       <= 1'b0;
                        out_status      <= 2'd0;
                        out_implied_var <= '0;
                        out_new_val     <= 1'b0;
                        out_overflow    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_chunk_clause_evaluator.sv
// Self-checking bench: directed clauses pinned to literal results, then randomized clauses
// against a literal-list reference model with random gaps and consumer back-pressure.
module tb_multi_chunk_clause_evaluator;

    localparam int L  = 5;
    localparam int VB = 8;
    localparam int MC = 4;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            in_first;
    logic            in_last;
    logic [L-1:0]    in_mask;
    logic [L-1:0]    in_unassign;
    logic [L-1:0]    in_val;
    logic [L-1:0]    in_pole;
    logic [L*VB-1:0] in_variable;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_status;
    logic [VB-1:0]   out_implied_var;
    logic            out_new_val;
    logic            out_overflow;

    multi_chunk_clause_evaluator #(
        .LITS_PER_CHUNK(L),
        .VAR_BITS(VB),
        .MAX_CHUNKS(MC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_first(in_first),
        .in_last(in_last),
        .in_mask(in_mask),
        .in_unassign(in_unassign),
        .in_val(in_val),
        .in_pole(in_pole),
        .in_variable(in_variable),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_status(out_status),
        .out_implied_var(out_implied_var),
        .out_new_val(out_new_val),
        .out_overflow(out_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          unassign;
        bit          val;
        bit          pole;
        bit [VB-1:0] v;
    } lit_t;

    typedef struct {
        bit [1:0]    status;
        bit [VB-1:0] implied;
        bit          nv;
        bit          ovf;
    } res_t;

    lit_t lits[$];
    res_t exp_q[$];
    res_t last_exp;
    bit   model_open;
    int   model_beats;
    int   checks;
    int   fails;
    int   stall_cycles;
    bit   cmp_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a clause is just the list of its active literals plus a beat count.
    task automatic commit_beat(input logic first, input logic last, input logic [L-1:0] mask,
                               input logic [L-1:0] unas, input logic [L-1:0] val,
                               input logic [L-1:0] pole, input logic [L*VB-1:0] vars);
        lit_t lt;
        res_t r;
        bit   sat;
        int   nfree;
        lit_t f;
        if (!model_open || first) begin
            lits.delete();
            model_beats = 0;
        end
        model_beats++;
        for (int i = 0; i < L; i++) begin
            if (mask[i]) begin
                lt.unassign = unas[i];
                lt.val      = val[i];
                lt.pole     = pole[i];
                lt.v        = vars[i*VB +: VB];
                lits.push_back(lt);
            end
        end
        if (last) begin
            sat   = 0;
            nfree = 0;
            f     = '{0, 0, 0, 0};
            foreach (lits[k]) begin
                if (!lits[k].unassign && (lits[k].val != lits[k].pole)) sat = 1;
                if (lits[k].unassign) begin
                    if (nfree == 0) f = lits[k];
                    nfree++;
                end
            end
            r.status  = sat ? 2'd1 : (nfree == 1) ? 2'd2 : (nfree == 0) ? 2'd3 : 2'd0;
            r.implied = (r.status == 2'd2) ? f.v : '0;
            r.nv      = (r.status == 2'd2) ? !f.pole : 1'b0;
            r.ovf     = (model_beats > MC);
            exp_q.push_back(r);
            last_exp   = r;
            model_open = 0;
        end else begin
            model_open = 1;
        end
    endtask

    task automatic send_beat(input logic first, input logic last, input logic [L-1:0] mask,
                             input logic [L-1:0] unas, input logic [L-1:0] val,
                             input logic [L-1:0] pole, input logic [L*VB-1:0] vars);
        int waited = 0;
        @(negedge clock);
        in_valid    = 1'b1;
        in_first    = first;
        in_last     = last;
        in_mask     = mask;
        in_unassign = unas;
        in_val      = val;
        in_pole     = pole;
        in_variable = vars;
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        commit_beat(first, last, mask, unas, val, pole, vars);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [L*VB-1:0] vslot(input int slot, input int v);
        logic [L*VB-1:0] r;
        r = '0;
        r[slot*VB +: VB] = VB'(v);
        return r;
    endfunction

    task automatic check_lit(input string name, input logic [1:0] st, input logic [VB-1:0] iv,
                             input logic nv, input logic ovf);
        chk({name, "_status"}, 32'(last_exp.status), 32'(st));
        chk({name, "_var"}, 32'(last_exp.implied), 32'(iv));
        chk({name, "_newval"}, 32'(last_exp.nv), 32'(nv));
        chk({name, "_ovf"}, 32'(last_exp.ovf), 32'(ovf));
    endtask

    // Single owner of out_ready; checks every cycle against the oldest pending result.
    always @(negedge clock) begin
        if (cmp_en) begin
            if (exp_q.size() != 0) begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("in_ready_result", 32'(in_ready), 32'd0);
                chk("out_status", 32'(out_status), 32'(exp_q[0].status));
                chk("out_implied_var", 32'(out_implied_var), 32'(exp_q[0].implied));
                chk("out_new_val", 32'(out_new_val), 32'(exp_q[0].nv));
                chk("out_overflow", 32'(out_overflow), 32'(exp_q[0].ovf));
                if (stall_cycles > 0) begin
                    out_ready = 1'b0;
                    stall_cycles--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready && out_valid) void'(exp_q.pop_front());
            end else begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
                chk("idle_outputs", {27'd0, out_status, out_new_val, out_overflow, |out_implied_var}, 32'd0);
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    initial begin
        int nb;
        int waited;
        logic [L-1:0] m, u, p, vv;
        logic first;
        checks       = 0;
        fails        = 0;
        stall_cycles = 0;
        cmp_en       = 0;
        model_open   = 0;
        model_beats  = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_first     = 1'b0;
        in_last      = 1'b0;
        in_mask      = '0;
        in_unassign  = '0;
        in_val       = '0;
        in_pole      = '0;
        in_variable  = '0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clock);
        cmp_en = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        send_beat(1, 1, 5'b00011, 5'b00001, 5'b00000, 5'b00000, vslot(0, 9));
        check_lit("t1_unit", 2'd2, 8'd9, 1'b1, 1'b0);

        send_beat(1, 0, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0);
        send_beat(0, 1, 5'b00100, 5'b00100, 5'b00000, 5'b00100, vslot(2, 40));
        check_lit("t2_unit2", 2'd2, 8'd40, 1'b0, 1'b0);

        send_beat(1, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 3));
        send_beat(0, 0, 5'b00001, 5'b00000, 5'b00001, 5'b00000, '0);
        send_beat(0, 1, 5'b00010, 5'b00010, 5'b00000, 5'b00000, vslot(1, 7));
        check_lit("t3_sat", 2'd1, 8'd0, 1'b0, 1'b0);

        send_beat(1, 1, 5'b00000, 5'b11111, 5'b10101, 5'b01010, '1);
        check_lit("t4_empty", 2'd3, 8'd0, 1'b0, 1'b0);

        send_beat(1, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 5));
        idle(2);
        send_beat(0, 1, 5'b00010, 5'b00010, 5'b00000, 5'b00000, vslot(1, 6));
        check_lit("t5_unres", 2'd0, 8'd0, 1'b0, 1'b0);

        stall_cycles = 3;
        for (int b = 0; b < 4; b++) send_beat(b == 0, 0, 5'b11111, 5'b00000, 5'b00000, 5'b00000, '0);
        send_beat(0, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 33));
        check_lit("t6_ovf", 2'd2, 8'd33, 1'b1, 1'b1);

        send_beat(1, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 11));
        send_beat(1, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, '0);
        send_beat(0, 1, 5'b00010, 5'b00010, 5'b00000, 5'b00010, vslot(1, 12));
        check_lit("t7_restart", 2'd2, 8'd12, 1'b0, 1'b0);

        send_beat(1, 0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 21));
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        model_open = 0;
        @(negedge clock);
        reset = 1'b0;
        send_beat(0, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, vslot(0, 20));
        check_lit("t8_reset", 2'd2, 8'd20, 1'b1, 1'b0);

        for (int c = 0; c < 150; c++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                first = (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
                m  = L'($urandom);
                u  = L'($urandom & $urandom & $urandom);
                p  = L'($urandom);
                vv = p ^ L'($urandom & $urandom & $urandom & $urandom);
                send_beat(first, b == nb - 1, m, u, vv, p, {$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        idle(1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
